meta_intf_rr_dispatcher: RTL and testbench
==========================================

META_INTF_RR_DISPATCHER -- requirements
Module: meta_intf_rr_dispatcher

Interface
REQ-001 SHALL have parameter N_INTERFACES, default N_STRM_AXI: number of output interfaces, legal range 2..16.
REQ-002 SHALL have parameter STYPE, default logic[63:0]: type of the data field on every interface.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port intf_in, metaIntf.s, STYPE: single input stream (valid/ready/data).
REQ-006 SHALL have port intf_out[N_INTERFACES], metaIntf.m array, STYPE: output streams, one per downstream consumer.

Function
REQ-007 SHALL distribute each accepted input item to exactly one output, with no loss, duplication or reordering per output.
REQ-008 SHALL hold one input register: in_data and in_valid.
- intf_in.ready = !in_valid | dispatch (combinational).
REQ-009 SHALL load in_data and set in_valid when intf_in.valid & intf_in.ready.
- SHALL clear in_valid when the register is dispatched and no new item is accepted in the same cycle.
REQ-010 SHALL hold one registered output slot per output: out_valid[i] and out_data[i], driving intf_out[i].valid and intf_out[i].data directly.
REQ-011 Slot i SHALL be free when !out_valid[i] | intf_out[i].ready.
- When free and not selected, out_valid[i] SHALL clear at the next edge.
REQ-012 dispatch = in_valid & (any slot free).
- Selection: rr_next if free; otherwise the first free slot scanning cyclically from rr_next+1.
REQ-013 On dispatch, the selected slot SHALL load in_data with out_valid=1.
- rr_next SHALL advance by 1, wrapping N_INTERFACES-1 -> 0.
- rr_next SHALL NOT change when no dispatch occurs.
REQ-014 The rr_next pointer width SHALL be $clog2(N_INTERFACES), with a minimum of 1 bit.
REQ-015 Latency SHALL be 2 cycles: an item accepted at edge t appears valid on an output after edge t+1.
REQ-016 Sustained throughput SHALL be 1 item per cycle while at least one slot is free each cycle.
REQ-017 Output valid SHALL stay asserted and data SHALL stay stable until that output's ready is seen high.
REQ-018 Boundary conditions:
- All slots full and none ready: in_valid held, intf_in.ready=0.
- Slot freeing and selected in the same cycle: the old item completes, the new item loads (back-to-back).
- rr_next slot blocked: skip per REQ-012, rr_next still advances by 1.
- Input arriving while in_valid=1 and dispatching in the same cycle: accepted, no bubble.
REQ-019 There SHALL be no combinational path from intf_in.valid to any intf_out signal.
- intf_in.ready MAY depend combinationally on intf_out[*].ready.

Reset
REQ-020 While rst_n=0 at posedge clk, the block SHALL clear in_valid, all out_valid and rr_next.
- Consequences: intf_out[*].valid=0 and intf_in.ready=1 after reset.
- Data registers SHALL NOT be reset.
REQ-021 Reset asserted mid-operation SHALL discard all buffered items; no partial transfer SHALL complete after the reset edge.
REQ-022 rst_n SHALL be used directly, without a resynchronizer stage.

Structure
REQ-023 SHALL use metaIntf and N_STRM_AXI from the shared lynxTypes package.
- SHALL add no new package typedefs; the pointer width is a module-local localparam.
REQ-024 SHALL be a single module with no sub-modules.
- The cyclic free-slot search is a combinational block inside the module.
REQ-025 SHALL be directly chainable with the round-robin metaIntf arbiter (dispatcher outputs to arbiter inputs), with identical N_INTERFACES and STYPE.

Verification (N_INTERFACES=4, STYPE 64 bits)
REQ-026 Reset: rst_n low 3 cycles mid-stream -> all intf_out valid=0, intf_in.ready=1, rr_next=0; items buffered before the reset never appear.
REQ-027 All outputs always ready, input 0x10..0x17 back-to-back -> outputs 0,1,2,3,0,1,2,3 receive 0x10..0x17 in order, one item per cycle, first valid 2 cycles after the first accept.
REQ-028 Output 1 held not-ready, others ready, inputs 0xA0..0xA3 -> 0xA0 to out0, 0xA1 to out1 (stalled, data held stable), 0xA2 to out2, 0xA3 to out3; no input stall.
REQ-029 All outputs not-ready for 10 cycles with input streaming -> 4 slots plus the input register fill (5 items), then intf_in.ready=0; on release all 5 items are delivered with none lost.
REQ-030 Random valid/ready on all ports, 10k items -> per-output order is preserved, the total output set equals the input set, and no output receives more than 2 more items than any other when all are always ready.
REQ-031 Chained with the arbiter, 1000 items, random backpressure -> arbiter output multiset equals the input multiset.

Source files
------------

// File: rtl/lynx_types_pkg.sv
// Shared stream-platform types: the default stream count used by the
// metaIntf plumbing blocks.
package lynxTypes;

    localparam int N_STRM_AXI = 4;

endpackage

// File: rtl/meta_intf.sv
// Generic valid/ready/data stream interface; the producer side uses the m
// modport and the consumer side uses the s modport.
interface metaIntf #(
    parameter type STYPE = logic [63:0]
);

    logic valid;
    logic ready;
    STYPE data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);

endinterface

// File: rtl/meta_intf_rr_dispatcher.sv
// Round-robin dispatcher: one input stream fanned out to N_INTERFACES output
// streams through one input register and one registered slot per output.
module meta_intf_rr_dispatcher
    import lynxTypes::*;
#(
    parameter int  N_INTERFACES = N_STRM_AXI,
    parameter type STYPE        = logic [63:0]
) (
    input  logic clk,
    input  logic rst_n,
    metaIntf.s   intf_in,
    metaIntf.m   intf_out [N_INTERFACES]
);

    localparam int PTR_W = (N_INTERFACES > 2) ? $clog2(N_INTERFACES) : 1;

    logic                    in_valid_q, in_valid_d;
    STYPE                    in_data_q, in_data_d;
    logic [N_INTERFACES-1:0] out_valid_q, out_valid_d;
    STYPE                    out_data_q [N_INTERFACES];
    STYPE                    out_data_d [N_INTERFACES];
    logic [PTR_W-1:0]        rr_next_q, rr_next_d;

    logic [N_INTERFACES-1:0] out_ready;
    logic [N_INTERFACES-1:0] slot_free;
    logic [PTR_W-1:0]        sel_idx;
    logic                    dispatch;
    logic                    in_ready;

    for (genvar gi = 0; gi < N_INTERFACES; gi++) begin : g_out
        assign intf_out[gi].valid = out_valid_q[gi];
        assign intf_out[gi].data  = out_data_q[gi];
        assign out_ready[gi]      = intf_out[gi].ready;
    end

    assign slot_free     = ~out_valid_q | out_ready;
    assign dispatch      = in_valid_q & (|slot_free);
    assign in_ready      = ~in_valid_q | dispatch;
    assign intf_in.ready = in_ready;

    // First free slot at or after rr_next, wrapping at N_INTERFACES.
    always_comb begin
        logic             found;
        logic [PTR_W:0]   cand;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        found   = 1'b0;
        sel_idx = rr_next_q;
        cand    = '0;
        for (int k = 0; k < N_INTERFACES; k++) begin
            cand = {1'b0, rr_next_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N_INTERFACES)) begin
                cand = cand - (PTR_W+1)'(N_INTERFACES);
            end
            if (!found && slot_free[cand[PTR_W-1:0]]) begin
                found   = 1'b1;
                sel_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        in_valid_d = in_valid_q;
        in_data_d  = in_data_q;
        if (intf_in.valid && in_ready) begin
            in_valid_d = 1'b1;
            in_data_d  = intf_in.data;
        end else if (dispatch) begin
            in_valid_d = 1'b0;
        end
    end

    // A slot being drained this cycle may be refilled in the same cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int i = 0; i < N_INTERFACES; i++) begin
            if (dispatch && (sel_idx == PTR_W'(i))) begin
                out_valid_d[i] = 1'b1;
                out_data_d[i]  = in_data_q;
            end else if (slot_free[i]) begin
                out_valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        rr_next_d = rr_next_q;
        if (dispatch) begin
            rr_next_d = (rr_next_q == PTR_W'(N_INTERFACES - 1)) ? '0 : rr_next_q + 1'b1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_valid_q  <= 1'b0;
            out_valid_q <= '0;
            rr_next_q   <= '0;
        end else begin
            in_valid_q  <= in_valid_d;
            out_valid_q <= out_valid_d;
            rr_next_q   <= rr_next_d;
        end
    end

    // NOTE: payload registers carry no reset; their valid bits gate every use.
    always_ff @(posedge clk) begin
        in_data_q  <= in_data_d;
        out_data_q <= out_data_d;
    end

endmodule

// File: tb/tb_meta_intf_rr_dispatcher.sv
// Self-checking bench for meta_intf_rr_dispatcher: directed vector tables,
// hand-written stall/reset sequences and a model-checked random run.
module tb_meta_intf_rr_dispatcher;

    localparam int N = 4;
    typedef logic [63:0] data_t;

    typedef struct {
        logic              iv;
        data_t             id;
        logic [N-1:0]      ordy;
        logic              exp_irdy;
        logic [N-1:0]      exp_ov;
        logic [N-1:0][63:0] exp_d;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    metaIntf #(.STYPE(data_t)) in_if ();
    metaIntf #(.STYPE(data_t)) out_if [N] ();

    logic [N-1:0] out_ready;
    logic [N-1:0] out_valid;
    data_t        out_data [N];

    for (genvar g = 0; g < N; g++) begin : g_tap
        assign out_valid[g]    = out_if[g].valid;
        assign out_data[g]     = out_if[g].data;
        assign out_if[g].ready = out_ready[g];
    end

    meta_intf_rr_dispatcher #(.N_INTERFACES(N), .STYPE(data_t)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .intf_in  (in_if),
        .intf_out (out_if)
    );

    int vectors;
    int errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        out_ready   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic vec_t v(input logic iv, input data_t id, input logic [N-1:0] ordy,
                               input logic irdy, input logic [N-1:0] ov,
                               input data_t d0, input data_t d1, input data_t d2, input data_t d3);
        vec_t r;
        r.iv = iv; r.id = id; r.ordy = ordy; r.exp_irdy = irdy; r.exp_ov = ov;
        r.exp_d = {d3, d2, d1, d0};
        return r;
    endfunction

    task automatic run_table(input string tag, input vec_t tbl[$]);
        foreach (tbl[n]) begin
            in_if.valid = tbl[n].iv;
            in_if.data  = tbl[n].id;
            out_ready   = tbl[n].ordy;
            @(negedge clk);
            check($sformatf("%s%0d_in_ready", tag, n), in_if.ready, tbl[n].exp_irdy);
            check($sformatf("%s%0d_out_valid", tag, n), out_valid, tbl[n].exp_ov);
            for (int i = 0; i < N; i++) begin
                if (tbl[n].exp_ov[i]) begin
                    check($sformatf("%s%0d_out%0d_data", tag, n, i), out_data[i], tbl[n].exp_d[i]);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: input register as a 0/1-entry queue, slots as
    // occupied flags, pointer as a plain integer modulo N.
    logic  m_full [N];
    data_t m_val  [N];
    data_t m_inq  [$];
    int    m_ptr;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        m_inq.delete();
        m_ptr = 0;
    endfunction

    function automatic logic model_irdy(input logic [N-1:0] rdy);
        if (m_inq.size() == 0) return 1'b1;
        for (int i = 0; i < N; i++) if (!m_full[i] || rdy[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step(input logic iv, input data_t d, input logic [N-1:0] rdy);
        logic acc;
        int   s;
        acc = iv && model_irdy(rdy);
        for (int i = 0; i < N; i++) if (m_full[i] && rdy[i]) m_full[i] = 1'b0;
        if (m_inq.size() > 0) begin
            for (int k = 0; k < N; k++) begin
                s = (m_ptr + k) % N;
                if (!m_full[s]) begin
                    m_full[s] = 1'b1;
                    m_val[s]  = m_inq.pop_front();
                    m_ptr     = (m_ptr + 1) % N;
                    break;
                end
            end
        end
        if (acc) m_inq.push_back(d);
    endfunction

    task automatic run_random(input string tag, input int n_items, input bit all_ready);
        int           accepted, delivered, cycles, mx, mn;
        int           cnt [N];
        logic [N-1:0] exp_ov;
        logic         exp_irdy;
        data_t        cur;
        do_reset();
        model_reset();
        accepted = 0; delivered = 0; cycles = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        cur = {32'($urandom), 32'(0)};
        while ((accepted < n_items || cycles < n_items * 8 + 10) && cycles < n_items * 8 + 10) begin
            if (accepted >= n_items) break;
            in_if.valid = ($urandom_range(0, 99) < 70);
            in_if.data  = cur;
            for (int i = 0; i < N; i++) out_ready[i] = all_ready ? 1'b1 : ($urandom_range(0, 99) < 60);
            @(negedge clk);
            for (int i = 0; i < N; i++) exp_ov[i] = m_full[i];
            exp_irdy = model_irdy(out_ready);
            check({tag, "_in_ready"}, in_if.ready, exp_irdy);
            check({tag, "_out_valid"}, out_valid, exp_ov);
            for (int i = 0; i < N; i++) begin
                if (exp_ov[i]) check($sformatf("%s_out%0d_data", tag, i), out_data[i], m_val[i]);
                if (out_valid[i] && out_ready[i]) begin delivered++; cnt[i]++; end
            end
            if (in_if.valid && exp_irdy) begin
                accepted++;
                cur = {32'($urandom), 32'(accepted)};
            end
            model_step(in_if.valid, in_if.data, out_ready);
            cycles++;
            @(posedge clk);
            #1;
        end
        check({tag, "_items_accepted"}, accepted, n_items);
        in_if.valid = 1'b0;
        out_ready   = '1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) exp_ov[i] = m_full[i];
            check({tag, "_drain_out_valid"}, out_valid, exp_ov);
            for (int i = 0; i < N; i++) begin
                if (exp_ov[i]) check($sformatf("%s_drain%0d_data", tag, i), out_data[i], m_val[i]);
                if (out_valid[i]) begin delivered++; cnt[i]++; end
            end
            model_step(1'b0, '0, out_ready);
            @(posedge clk);
            #1;
        end
        check({tag, "_delivered_total"}, delivered, accepted);
        if (all_ready) begin
            mx = cnt[0]; mn = cnt[0];
            for (int i = 1; i < N; i++) begin
                if (cnt[i] > mx) mx = cnt[i];
                if (cnt[i] < mn) mn = cnt[i];
            end
            check({tag, "_fairness_spread_ok"}, (mx - mn) <= 2, 1);
        end
    endtask

    initial begin
        vec_t  t1 [$];
        vec_t  t2 [$];
        data_t got [N][$];
        int    n_acc;
        logic  last_irdy;

        vectors = 0;
        errors  = 0;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        out_ready   = '0;

        do_reset();
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_if.ready, 1);
        @(posedge clk);
        #1;

        // All outputs ready, 0x10..0x17 back-to-back.
        t1.push_back(v(1, 64'h10, 4'hF, 1, 4'b0000, 0, 0, 0, 0));
        t1.push_back(v(1, 64'h11, 4'hF, 1, 4'b0000, 0, 0, 0, 0));
        t1.push_back(v(1, 64'h12, 4'hF, 1, 4'b0001, 64'h10, 0, 0, 0));
        t1.push_back(v(1, 64'h13, 4'hF, 1, 4'b0010, 0, 64'h11, 0, 0));
        t1.push_back(v(1, 64'h14, 4'hF, 1, 4'b0100, 0, 0, 64'h12, 0));
        t1.push_back(v(1, 64'h15, 4'hF, 1, 4'b1000, 0, 0, 0, 64'h13));
        t1.push_back(v(1, 64'h16, 4'hF, 1, 4'b0001, 64'h14, 0, 0, 0));
        t1.push_back(v(1, 64'h17, 4'hF, 1, 4'b0010, 0, 64'h15, 0, 0));
        t1.push_back(v(0, 64'h0,  4'hF, 1, 4'b0100, 0, 0, 64'h16, 0));
        t1.push_back(v(0, 64'h0,  4'hF, 1, 4'b1000, 0, 0, 0, 64'h17));
        t1.push_back(v(0, 64'h0,  4'hF, 1, 4'b0000, 0, 0, 0, 0));
        run_table("b2b", t1);

        // Output 1 held not-ready: its item waits stable, input never stalls.
        t2.push_back(v(1, 64'hA0, 4'b1101, 1, 4'b0000, 0, 0, 0, 0));
        t2.push_back(v(1, 64'hA1, 4'b1101, 1, 4'b0000, 0, 0, 0, 0));
        t2.push_back(v(1, 64'hA2, 4'b1101, 1, 4'b0001, 64'hA0, 0, 0, 0));
        t2.push_back(v(1, 64'hA3, 4'b1101, 1, 4'b0010, 0, 64'hA1, 0, 0));
        t2.push_back(v(0, 64'h0,  4'b1101, 1, 4'b0110, 0, 64'hA1, 64'hA2, 0));
        t2.push_back(v(0, 64'h0,  4'b1101, 1, 4'b1010, 0, 64'hA1, 0, 64'hA3));
        t2.push_back(v(0, 64'h0,  4'b1101, 1, 4'b0010, 0, 64'hA1, 0, 0));
        t2.push_back(v(0, 64'h0,  4'b1111, 1, 4'b0010, 0, 64'hA1, 0, 0));
        t2.push_back(v(0, 64'h0,  4'b1111, 1, 4'b0000, 0, 0, 0, 0));
        run_table("stall1_", t2);

        // Every output blocked for 10 cycles: 4 slots plus the input register fill.
        n_acc = 0;
        last_irdy = 1'b1;
        out_ready = '0;
        for (int c = 0; c < 10; c++) begin
            in_if.valid = 1'b1;
            in_if.data  = 64'hC0 + 64'(n_acc);
            @(negedge clk);
            last_irdy = in_if.ready;
            if (in_if.ready) n_acc++;
            @(posedge clk);
            #1;
        end
        check("full_accepted_count", n_acc, 5);
        check("full_in_ready", last_irdy, 0);
        check("full_out_valid", out_valid, 4'hF);
        for (int i = 0; i < N; i++) check($sformatf("full_out%0d_data", i), out_data[i], 64'hC0 + 64'(i));
        in_if.valid = 1'b0;
        out_ready   = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (out_valid[i]) got[i].push_back(out_data[i]);
            @(posedge clk);
            #1;
        end
        check("release_out0_count", got[0].size(), 2);
        for (int i = 1; i < N; i++) check($sformatf("release_out%0d_count", i), got[i].size(), 1);
        for (int i = 0; i < N; i++) if (got[i].size() > 0) check($sformatf("release_out%0d_first", i), got[i][0], 64'hC0 + 64'(i));
        if (got[0].size() > 1) check("release_out0_second", got[0][1], 64'hC4);

        // Reset mid-stream: buffered items are discarded, pointer restarts at 0.
        out_ready = '0;
        for (int c = 0; c < 3; c++) begin
            in_if.valid = 1'b1;
            in_if.data  = 64'hE0 + 64'(c);
            @(posedge clk);
            #1;
        end
        in_if.valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = '1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("midrst%0d_out_valid", c), out_valid, 0);
            check($sformatf("midrst%0d_in_ready", c), in_if.ready, 1);
            @(posedge clk);
            #1;
        end
        in_if.valid = 1'b1;
        in_if.data  = 64'hF0;
        @(negedge clk);
        check("postrst_accept_ready", in_if.ready, 1);
        @(posedge clk);
        #1 in_if.valid = 1'b0;
        @(negedge clk);
        check("postrst_lat1_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("postrst_lat2_out_valid", out_valid, 4'b0001);
        check("postrst_lat2_out0_data", out_data[0], 64'hF0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("postrst_idle_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        run_random("rnd", 10000, 1'b0);
        run_random("fair", 2000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
